// File: rtl/mem_line_arbiter_pkg.sv
// Shared types and constants for the line-fill memory arbiter.
// Owner encoding doubles as the round-robin "last served" value.
package mem_pkg;

    localparam int MEM_ADDR_W = 26;
    localparam int MEM_LINE_W = 512;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_DONE,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/mem_line_arbiter_if.sv
// Line-fill memory port: level request out, level ack back.
// master = arbiter side, slave = backing line memory.
interface mem_line_arbiter_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int LINE_W = MEM_LINE_W
);

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/mem_line_arbiter_rr_arb2.sv
// Two-way I/D picker: round-robin on collision, optional D priority.
// rr_last records the side granted most recently.
module rr_arb2
    import mem_pkg::*;
#(
    parameter int FIXED_PRI = 0
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_req,
    input  logic d_req,
    input  logic take,
    output logic pick
);

    logic rr_last;

    always_comb begin
        pick = OWNER_I;
        unique case ({i_req, d_req})
            2'b01:   pick = OWNER_D;
            2'b11:   pick = (FIXED_PRI != 0) ? OWNER_D : ~rr_last;
            default: pick = OWNER_I;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_last <= OWNER_D;
        end else if (take) begin
            rr_last <= pick;
        end
    end

endmodule

// File: rtl/mem_line_arbiter.sv
// Shares one line-fill memory port between the I-side and D-side
// L2 miss paths, one transaction at a time, with a timeout abort.
module mem_line_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W    = MEM_ADDR_W,
    parameter int LINE_W    = MEM_LINE_W,
    parameter int TIMEOUT   = 1024,
    parameter int FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_done,
    output logic [LINE_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    mem_line_arbiter_if.master mem
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [LINE_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt;
    logic              ack_prev;
    logic              pick;
    logic              take;
    logic              ack_rise;
    logic              cnt_hit;

    assign take     = (state == S_IDLE) && (i_req || d_req);
    assign ack_rise = mem.mem_ack && !ack_prev;
    assign cnt_hit  = (cnt == CNT_LAST);
    assign busy     = (state != S_IDLE);

    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    rr_arb2 #(
        .FIXED_PRI(FIXED_PRI)
    ) u_arb (
        .clk  (clk),
        .rstn (rstn),
        .i_req(i_req),
        .d_req(d_req),
        .take (take),
        .pick (pick)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= S_IDLE;
            owner_q     <= OWNER_I;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            cnt         <= '0;
            ack_prev    <= 1'b0;
            rdata       <= '0;
            mem.mem_req <= 1'b0;
            i_done      <= 1'b0;
            d_done      <= 1'b0;
            err         <= 1'b0;
        end else begin
            ack_prev <= mem.mem_ack;
            i_done   <= 1'b0;
            d_done   <= 1'b0;
            err      <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (take) begin
                        owner_q <= pick;
                        if (pick == OWNER_D) begin
                            addr_q  <= d_addr;
                            we_q    <= d_we;
                            wdata_q <= d_wdata;
                        end else begin
                            addr_q  <= i_addr;
                            we_q    <= 1'b0;
                            wdata_q <= '0;
                        end
                        mem.mem_req <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                // The ISSUE cycle is the first counted cycle after mem_req rise.
                S_ISSUE: begin
                    cnt   <= CNT_W'(1);
                    state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (ack_rise || cnt_hit) begin
                        mem.mem_req <= 1'b0;
                        i_done      <= (owner_q == OWNER_I);
                        d_done      <= (owner_q == OWNER_D);
                        state       <= S_DONE;
                    end
                    if (ack_rise) begin
                        if (!we_q) begin
                            rdata <= mem.mem_rdata;
                        end
                    end else if (cnt_hit) begin
                        rdata <= '0;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!mem.mem_ack) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Randomized scoreboard bench for mem_line_arbiter with a
// transaction-level reference model and a behavioural line memory.
module tb_mem_line_arbiter;
    import mem_pkg::*;

    localparam int ADDR_W    = MEM_ADDR_W;
    localparam int LINE_W    = MEM_LINE_W;
    localparam int TIMEOUT   = 40;
    localparam int FIXED_PRI = 0;
    localparam int NEVER     = 100000;

    typedef struct {
        logic              side;
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [LINE_W-1:0] wdata;
        logic [LINE_W-1:0] line;
        int                lat;
        int                hold;
        logic              err;
        logic [LINE_W-1:0] rdata;
    } txn_t;

    logic              clk;
    logic              rstn;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_done;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic              d_done;
    logic [LINE_W-1:0] rdata;
    logic              err;
    logic              busy;

    mem_line_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) mif ();

    mem_line_arbiter #(
        .ADDR_W   (ADDR_W),
        .LINE_W   (LINE_W),
        .TIMEOUT  (TIMEOUT),
        .FIXED_PRI(FIXED_PRI)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .i_req  (i_req),
        .i_addr (i_addr),
        .i_done (i_done),
        .d_req  (d_req),
        .d_we   (d_we),
        .d_addr (d_addr),
        .d_wdata(d_wdata),
        .d_done (d_done),
        .rdata  (rdata),
        .err    (err),
        .busy   (busy),
        .mem    (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    txn_t exp_q[$];
    txn_t cfg_q[$];
    logic last_side = OWNER_D;
    logic [LINE_W-1:0] model_rdata = '0;

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        r = '0;
        for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Service order is known here, so outcome and rdata follow directly.
    function automatic void push(input txn_t t);
        t.err = (t.lat > TIMEOUT - 1);
        if (t.err) model_rdata = '0;
        else if (!t.we) model_rdata = t.line;
        t.rdata   = model_rdata;
        last_side = t.side;
        exp_q.push_back(t);
        cfg_q.push_back(t);
    endfunction

    // Monitor: checks the memory request and every completion.
    txn_t mon_cur;
    bit   mon_active = 0;
    int   mon_high   = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            mon_active = 0;
            mon_high   = 0;
        end else begin
            if (mif.mem_req) begin
                if (!mon_active) begin
                    mon_active = 1;
                    mon_high   = 0;
                    if (exp_q.size() == 0) begin
                        fail_evt("spurious_mem_req");
                    end else begin
                        mon_cur = exp_q[0];
                        check("mem_addr", LINE_W'(mif.mem_addr), LINE_W'(mon_cur.addr));
                        check("mem_we", LINE_W'(mif.mem_we), LINE_W'(mon_cur.we));
                        if (mon_cur.we) check("mem_wdata", mif.mem_wdata, mon_cur.wdata);
                        check("ack_low_at_req", LINE_W'(mif.mem_ack), '0);
                    end
                end
                mon_high++;
            end
            if (i_done || d_done) begin
                if (exp_q.size() == 0) begin
                    fail_evt("spurious_done");
                end else begin
                    mon_cur = exp_q.pop_front();
                    check("done_side", LINE_W'({i_done, d_done}),
                          LINE_W'(mon_cur.side ? 2'b01 : 2'b10));
                    check("err", LINE_W'(err), LINE_W'(mon_cur.err));
                    check("rdata", rdata, mon_cur.rdata);
                    check("req_cycles", LINE_W'(mon_high),
                          LINE_W'(mon_cur.err ? TIMEOUT : mon_cur.lat + 1));
                    check("busy_done", LINE_W'(busy), LINE_W'(1'b1));
                end
                mon_active = 0;
            end
            if (!mif.mem_req && mif.mem_ack) check("busy_drain", LINE_W'(busy), LINE_W'(1'b1));
        end
    end

    // Line memory: acks L cycles after request rise, holds ack a while.
    txn_t s_cur;
    bit   s_active = 0;
    bit   s_acked  = 0;
    int   s_cnt    = 0;

    always @(negedge clk) begin
        mif.mem_rdata = rand_line();
        if (!rstn) begin
            cfg_q.delete();
            s_active    = 0;
            mif.mem_ack = 1'b0;
        end else if (!s_active) begin
            if (mif.mem_req) begin
                if (cfg_q.size() > 0) begin
                    s_cur = cfg_q.pop_front();
                end else begin
                    s_cur.lat  = NEVER;
                    s_cur.hold = 0;
                end
                s_active = 1;
                s_acked  = 0;
                s_cnt    = 0;
            end
        end else begin
            s_cnt++;
            if (mif.mem_req) begin
                if (!s_acked && s_cnt == s_cur.lat) begin
                    mif.mem_ack   = 1'b1;
                    mif.mem_rdata = s_cur.line;
                    s_acked       = 1;
                end
            end else if (!s_acked || s_cur.hold == 0) begin
                mif.mem_ack = 1'b0;
                s_active    = 0;
            end else begin
                s_cur.hold--;
            end
        end
    end

    task automatic finish_scn(input bit ip_in, input bit dp_in);
        bit ip = ip_in;
        bit dp = dp_in;
        int budget = 3 * (TIMEOUT + 16);
        while ((ip || dp) && budget > 0) begin
            @(negedge clk);
            budget--;
            if (i_done && ip) begin
                i_req  = 1'b0;
                ip     = 0;
                i_addr = ADDR_W'($urandom);
            end
            if (d_done && dp) begin
                d_req   = 1'b0;
                dp      = 0;
                d_we    = 1'($urandom);
                d_addr  = ADDR_W'($urandom);
                d_wdata = rand_line();
            end
        end
        if (ip || dp) begin
            checks++;
            errors++;
            $display("FAIL done_wait actual=missing required=done");
            i_req = 1'b0;
            d_req = 1'b0;
        end
        budget = 20;
        while (s_active && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (2) @(negedge clk);
        check("idle_busy", LINE_W'(busy), '0);
        check("idle_mem_req", LINE_W'(mif.mem_req), '0);
    endtask

    task automatic run_scn(input int kind, input int lat_i, input int lat_d,
                           input logic d_write, input int fix_addr);
        txn_t ti;
        txn_t td;
        ti.side  = OWNER_I;
        ti.addr  = (fix_addr >= 0) ? ADDR_W'(fix_addr) : ADDR_W'($urandom);
        ti.we    = 1'b0;
        ti.wdata = '0;
        ti.line  = rand_line();
        ti.lat   = lat_i;
        ti.hold  = $urandom_range(0, 5);
        td.side  = OWNER_D;
        td.addr  = ADDR_W'($urandom);
        td.we    = d_write;
        td.wdata = rand_line();
        td.line  = rand_line();
        td.lat   = lat_d;
        td.hold  = $urandom_range(0, 5);
        case (kind)
            0: push(ti);
            1: push(td);
            2: begin
                if (FIXED_PRI != 0 || last_side == OWNER_I) begin
                    push(td);
                    push(ti);
                end else begin
                    push(ti);
                    push(td);
                end
            end
            3: begin
                push(ti);
                push(td);
            end
            default: begin
                push(td);
                push(ti);
            end
        endcase
        @(negedge clk);
        i_addr  = ti.addr;
        d_addr  = td.addr;
        d_we    = td.we;
        d_wdata = td.wdata;
        case (kind)
            0: i_req = 1'b1;
            1: d_req = 1'b1;
            2: begin
                i_req = 1'b1;
                d_req = 1'b1;
            end
            3: begin
                i_req = 1'b1;
                @(negedge clk);
                d_req = 1'b1;
            end
            default: begin
                d_req = 1'b1;
                @(negedge clk);
                i_req = 1'b1;
            end
        endcase
        finish_scn(kind != 1, kind != 0);
    endtask

    function automatic int rand_lat();
        int r = $urandom_range(0, 9);
        if (r == 0) return NEVER;
        if (r == 1) return TIMEOUT - 1;
        if (r == 2) return TIMEOUT;
        return $urandom_range(1, TIMEOUT - 2);
    endfunction

    task automatic reset_mid_txn();
        txn_t t;
        t.side  = OWNER_I;
        t.addr  = ADDR_W'($urandom);
        t.we    = 1'b0;
        t.wdata = '0;
        t.line  = rand_line();
        t.lat   = NEVER;
        t.hold  = 0;
        push(t);
        @(negedge clk);
        i_addr = t.addr;
        i_req  = 1'b1;
        repeat (6) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("rst_mem_req", LINE_W'(mif.mem_req), '0);
        check("rst_busy", LINE_W'(busy), '0);
        check("rst_no_done", LINE_W'({i_done, d_done}), '0);
        check("rst_rdata", rdata, '0);
        #1;
        last_side   = OWNER_D;
        model_rdata = '0;
        t.line      = rand_line();
        t.lat       = $urandom_range(1, 10);
        t.hold      = 2;
        push(t);
        rstn = 1'b1;
        finish_scn(1, 0);
    endtask

    initial begin
        rstn          = 1'b0;
        i_req         = 1'b0;
        i_addr        = '0;
        d_req         = 1'b0;
        d_we          = 1'b0;
        d_addr        = '0;
        d_wdata       = '0;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("reset_mem_req", LINE_W'(mif.mem_req), '0);
        check("reset_busy", LINE_W'(busy), '0);
        check("reset_done", LINE_W'({i_done, d_done}), '0);
        check("reset_err", LINE_W'(err), '0);
        check("reset_rdata", rdata, '0);
        check("reset_mem_we", LINE_W'(mif.mem_we), '0);
        rstn = 1'b1;

        run_scn(0, 34, 1, 1'b0, 32'h0402);
        run_scn(2, 5, 7, 1'b0, -1);
        run_scn(2, 3, 4, 1'b1, -1);
        run_scn(1, TIMEOUT - 1, TIMEOUT - 1, 1'b0, -1);
        run_scn(1, TIMEOUT, TIMEOUT, 1'b0, -1);
        run_scn(0, NEVER, 1, 1'b0, -1);
        run_scn(1, 2, 2, 1'b1, -1);
        run_scn(0, 1, 1, 1'b0, -1);
        run_scn(3, 4, 6, 1'b1, -1);
        run_scn(4, 6, 4, 1'b0, -1);
        for (int n = 0; n < 40; n++) begin
            run_scn($urandom_range(0, 4), rand_lat(), rand_lat(), 1'($urandom), -1);
        end
        reset_mid_txn();
        run_scn(2, 3, 3, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
